// File: rtl/pc_next_unit.sv
// pc_next_unit: program counter with redirect priority, stall, fetch handshake and fetch counter.
// Optional macro PC_MISALIGN_TRAP_EN sends misaligned redirect targets to TRAP_VEC.
`default_nettype none

module pc_next_unit #(
    parameter int                 XLEN      = 32,
    parameter int                 INC       = 4,
    parameter logic [XLEN-1:0]    RESET_VEC = 32'h0000_0000,
    parameter logic [XLEN-1:0]    TRAP_VEC  = 32'h0000_0100,
    parameter int                 CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_i,
    input  logic              branch_taken_i,
    input  logic [XLEN-1:0]   branch_target_i,
    input  logic              jump_en_i,
    input  logic [XLEN-1:0]   jump_target_i,
    input  logic              imem_req_ready_i,
    output logic              imem_req_valid_o,
    output logic [XLEN-1:0]   pc_out_o,
    output logic [XLEN-1:0]   pc_plus_inc_o,
    output logic [CNT_W-1:0]  fetch_cnt_o,
    output logic              misalign_trap_o
);

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid;
    logic               accept;
    logic               redirect;
    logic [XLEN-1:0]    raw_target;
    logic [XLEN-1:0]    target;
    logic [XLEN-1:0]    pc_seq;

    always_comb begin
        state_d = state_q;
        valid   = 1'b0;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: begin
                valid = 1'b1;
                if (stall_i) state_d = S_HOLD;
            end
            S_HOLD:  if (!stall_i) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
    end

    assign accept     = valid & imem_req_ready_i & ~stall_i;
    // Redirects are honoured in FETCH and HOLD regardless of stall or accept.
    assign redirect   = (jump_en_i | branch_taken_i) & (state_q != S_BOOT);
    assign raw_target = jump_en_i ? jump_target_i : branch_target_i;
    assign pc_seq     = pc_q + XLEN'(INC);

`ifdef PC_MISALIGN_TRAP_EN
    logic misalign;
    logic trap_q;

    assign misalign = (INC == 4) && (raw_target[1:0] != 2'b00);
    assign target   = misalign ? TRAP_VEC : {raw_target[XLEN-1:1], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) trap_q <= 1'b0;
        else        trap_q <= redirect & misalign;
    end

    assign misalign_trap_o = trap_q;
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(INC - 1));

    assign target          = raw_target & ALIGN_MASK;
    assign misalign_trap_o = 1'b0;
`endif

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (redirect)    pc_d = target;
        else if (accept) pc_d = pc_seq;
        if (accept)      cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VEC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req_valid_o = valid;
    assign pc_out_o         = pc_q;
    assign pc_plus_inc_o    = pc_seq;
    assign fetch_cnt_o      = cnt_q;

endmodule

`default_nettype wire
